symbol_histogram: RTL and testbench
===================================

SYMBOL_HISTOGRAM -- requirements
Module: symbol_histogram

Interface
REQ-001 The block SHALL have parameter SYM_W, default 4, meaning symbol width in bits.
REQ-002 The block SHALL have parameter NUM_SYM, default 10, meaning counted symbols 0..NUM_SYM-1 (2 <= NUM_SYM <= 2^SYM_W).
REQ-003 The block SHALL have parameter CNT_W, default 9, meaning per-symbol counter width.
REQ-004 The block SHALL have parameter MAX_LEN, default 256, meaning the maximum number of symbols accepted per run (1..2^16).
REQ-005 The block SHALL have these ports: Clk_in  input  1  sole clock; all logic on rising edge.
REQ-006 nRst  input  1  synchronous, active-low reset, sampled on the rising edge of Clk_in.
REQ-007 Start  input  1  single-cycle run request.
REQ-008 Data_in  input  SYM_W  input symbol.
REQ-009 Data_valid  input  1  Data_in is valid this cycle.
REQ-010 Data_ready  output  1  block accepts a symbol this cycle.
REQ-011 Busy  output  1  run in progress.
REQ-012 Done  output  1  histogram complete and readable (level).
REQ-013 Total  output  LEN_W = clog2(MAX_LEN+1)  symbols counted in the current or last run.
REQ-014 Sat  output  1  sticky: at least one counter saturated this run.
REQ-015 Rd_addr  input  clog2(NUM_SYM)  read-out symbol index.
REQ-016 Rd_data  output  CNT_W  count for Rd_addr, registered.

Function
REQ-017 The block SHALL implement an FSM with states IDLE, COUNT and DONE; Busy=(COUNT), Done=(DONE), Data_ready=(COUNT).
REQ-018 In IDLE or DONE, Start=1 SHALL clear all counters, Total and Sat, and enter COUNT on the next cycle.
REQ-019 Start in COUNT SHALL be ignored.
REQ-020 A symbol SHALL be accepted only when Data_valid and Data_ready are both 1.
REQ-021 An accepted symbol s < NUM_SYM SHALL increment count[s] by 1, saturating at 2^CNT_W-1, and increment Total by 1; the new values SHALL be visible the next cycle.
REQ-022 An increment attempted on a counter already at 2^CNT_W-1 SHALL leave it unchanged, still increment Total, and set Sat.
REQ-023 An accepted symbol s >= NUM_SYM is the terminator: it SHALL not be counted, SHALL not change Total, and SHALL move the FSM to DONE next cycle.
REQ-024 When an accepted counted symbol makes Total equal MAX_LEN, the block SHALL count it and move to DONE next cycle; no further symbol is accepted.
REQ-025 Data_valid=0 in COUNT SHALL hold all state; there is no timeout.
REQ-026 In DONE, counters, Total and Sat SHALL hold until the next Start or reset.
REQ-027 Rd_data SHALL equal count[Rd_addr] one cycle after Rd_addr is presented, in any state.
REQ-028 Rd_addr >= NUM_SYM SHALL return 0.
REQ-029 A read that coincides with an increment of the same index SHALL return the pre-increment value.

Reset
REQ-030 nRst=0 at a rising edge SHALL force IDLE, clear all counters and Rd_data, and set Total=0, Sat=0, Busy=0, Done=0, Data_ready=0; this overrides Start and any data.
REQ-031 Reset asserted during COUNT SHALL discard the partial run; no Done pulse follows.
REQ-032 There SHALL be no asynchronous or negedge-triggered logic; Start, Data_in and Data_valid SHALL be sampled only on rising edges of Clk_in.

Verification
REQ-033 Basic run, defaults: Start, then stream 3,3,7,0 and terminator 4'hF -> count[3]=2, count[7]=1, count[0]=1, Total=4, Done=1 one cycle after the terminator, Sat=0.
REQ-034 Length limit, MAX_LEN=8: 10 valid symbols of 5 with no terminator -> Data_ready drops after the 8th; count[5]=8, Total=8, symbols 9 and 10 not accepted.
REQ-035 Saturation, CNT_W=3: nine symbols of 2, then terminator -> count[2]=7, Total=9, Sat=1.
REQ-036 Backpressure and gaps: Data_valid toggled randomly over 50 symbols -> counts match a reference model; Start pulsed mid-run -> ignored.
REQ-037 Reset mid-run: nRst=0 after 5 symbols -> next cycle all counters=0, IDLE, Done=0; a new Start runs cleanly.
REQ-038 Readback: in DONE, sweep Rd_addr 0..15 -> Rd_data matches counts with 1-cycle latency; indices 10..15 read 0.

Source files
------------

// File: rtl/symbol_histogram.sv
// Per-symbol histogram over a bounded stream: counts symbols below NUM_SYM until
// a terminator (symbol >= NUM_SYM) or MAX_LEN counted symbols, then holds for readback.
module symbol_histogram #(
  parameter  int SYM_W   = 4,
  parameter  int NUM_SYM = 10,
  parameter  int CNT_W   = 9,
  parameter  int MAX_LEN = 256,
  localparam int LEN_W   = $clog2(MAX_LEN + 1),
  localparam int ADDR_W  = $clog2(NUM_SYM)
) (
  input  logic              Clk_in,
  input  logic              nRst,
  input  logic              Start,
  input  logic [SYM_W-1:0]  Data_in,
  input  logic              Data_valid,
  output logic              Data_ready,
  output logic              Busy,
  output logic              Done,
  output logic [LEN_W-1:0]  Total,
  output logic              Sat,
  input  logic [ADDR_W-1:0] Rd_addr,
  output logic [CNT_W-1:0]  Rd_data
);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state;
  logic [CNT_W-1:0]   count [NUM_SYM];
  logic [NUM_SYM-1:0] sel_hit;
  logic               sel_full;
  logic [CNT_W-1:0]   rd_word;
  logic               in_range;
  logic               accept;
  logic               counted;
  logic               term;
  logic               clear;
  logic               last;
  logic [LEN_W-1:0]   total_next;

  // Decode the incoming symbol and the read address one-hot against the counter bank.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    sel_hit  = '0;
    sel_full = 1'b0;
    rd_word  = '0;
    for (int i = 0; i < NUM_SYM; i++) begin
      if (Data_in == SYM_W'(i)) begin
        sel_hit[i] = 1'b1;
        sel_full   = (count[i] == CNT_MAX);
      end
      if (Rd_addr == ADDR_W'(i)) rd_word = count[i];
    end
  end

  assign in_range   = |sel_hit;
  assign accept     = Data_valid && Data_ready;
  assign counted    = accept && in_range;
  assign term       = accept && !in_range;
  assign clear      = Start && (state != S_COUNT);
  assign total_next = Total + 1'b1;
  assign last       = (total_next == LEN_W'(MAX_LEN));

  // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk_in) begin
    if (!nRst) begin
      state      <= S_IDLE;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Data_ready <= 1'b0;
      Total      <= '0;
      Sat        <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            state      <= S_COUNT;
            Busy       <= 1'b1;
            Done       <= 1'b0;
            Data_ready <= 1'b1;
            Total      <= '0;
            Sat        <= 1'b0;
          end
        end
        S_COUNT: begin
          if (counted) begin
            Total <= total_next;
            if (sel_full) Sat <= 1'b1;
          end
          if (term || (counted && last)) begin
            state      <= S_DONE;
            Busy       <= 1'b0;
            Data_ready <= 1'b0;
            Done       <= 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          Busy       <= 1'b0;
          Done       <= 1'b0;
          Data_ready <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the counter bank is a small flop array, not RAM, so clearing it on reset is cheap and required.
  always_ff @(posedge Clk_in) begin
    if (!nRst) begin
      for (int i = 0; i < NUM_SYM; i++) count[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SYM; i++) begin
        if (clear)
          count[i] <= '0;
        else if (counted && sel_hit[i] && !sel_full)
          count[i] <= count[i] + 1'b1;
      end
    end
  end

  // Registered readback sees the pre-increment value when read and update coincide.
  always_ff @(posedge Clk_in) begin
    if (!nRst) Rd_data <= '0;
    else       Rd_data <= rd_word;
  end

endmodule

// File: tb/tb_symbol_histogram.sv
// Bench for symbol_histogram: three parameterisations share one stimulus stream and
// are compared every cycle against a cycle-level integer model, plus directed checks.
module tb_symbol_histogram;

  logic       Clk_in = 1'b0;
  logic       nRst;
  logic       start;
  logic [3:0] data_in;
  logic       data_valid;
  logic [3:0] rd_addr;

  // Instance 0: defaults. Instance 1: MAX_LEN=8. Instance 2: CNT_W=3.
  logic       rdy_d, bsy_d, dn_d, sat_d;
  logic [8:0] tot_d;
  logic [8:0] rd_d;
  logic       rdy_l, bsy_l, dn_l, sat_l;
  logic [3:0] tot_l;
  logic [8:0] rd_l;
  logic       rdy_s, bsy_s, dn_s, sat_s;
  logic [8:0] tot_s;
  logic [2:0] rd_s;

  always #5 Clk_in = ~Clk_in;

  symbol_histogram u_def (
    .Clk_in(Clk_in), .nRst(nRst), .Start(start), .Data_in(data_in), .Data_valid(data_valid),
    .Data_ready(rdy_d), .Busy(bsy_d), .Done(dn_d), .Total(tot_d), .Sat(sat_d),
    .Rd_addr(rd_addr), .Rd_data(rd_d));

  symbol_histogram #(.MAX_LEN(8)) u_len (
    .Clk_in(Clk_in), .nRst(nRst), .Start(start), .Data_in(data_in), .Data_valid(data_valid),
    .Data_ready(rdy_l), .Busy(bsy_l), .Done(dn_l), .Total(tot_l), .Sat(sat_l),
    .Rd_addr(rd_addr), .Rd_data(rd_l));

  symbol_histogram #(.CNT_W(3)) u_sat (
    .Clk_in(Clk_in), .nRst(nRst), .Start(start), .Data_in(data_in), .Data_valid(data_valid),
    .Data_ready(rdy_s), .Busy(bsy_s), .Done(dn_s), .Total(tot_s), .Sat(sat_s),
    .Rd_addr(rd_addr), .Rd_data(rd_s));

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Reference model: 0 = idle, 1 = counting, 2 = done.
  int c_max_cnt [3] = '{511, 511, 7};
  int c_max_len [3] = '{256, 8, 256};
  int m_st  [3];
  int m_cnt [3][10];
  int m_tot [3];
  int m_sat [3];
  int m_rd  [3];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      if (!nRst) begin
        m_st[k] = 0; m_tot[k] = 0; m_sat[k] = 0; m_rd[k] = 0;
        for (int s = 0; s < 10; s++) m_cnt[k][s] = 0;
      end else begin
        m_rd[k] = (int'(rd_addr) < 10) ? m_cnt[k][int'(rd_addr)] : 0;
        if (m_st[k] != 1) begin
          if (start) begin
            m_st[k] = 1; m_tot[k] = 0; m_sat[k] = 0;
            for (int s = 0; s < 10; s++) m_cnt[k][s] = 0;
          end
        end else if (data_valid) begin
          if (int'(data_in) < 10) begin
            m_tot[k]++;
            if (m_cnt[k][int'(data_in)] == c_max_cnt[k]) m_sat[k] = 1;
            else m_cnt[k][int'(data_in)]++;
            if (m_tot[k] == c_max_len[k]) m_st[k] = 2;
          end else begin
            m_st[k] = 2;
          end
        end
      end
    end
  endtask

  task automatic cmp_inst(input int k, input logic rdy, input logic bsy, input logic dn,
                          input int tot, input logic st, input int rd);
    check($sformatf("i%0d_ready", k), int'(rdy), int'(m_st[k] == 1));
    check($sformatf("i%0d_busy", k),  int'(bsy), int'(m_st[k] == 1));
    check($sformatf("i%0d_done", k),  int'(dn),  int'(m_st[k] == 2));
    check($sformatf("i%0d_total", k), tot, m_tot[k]);
    check($sformatf("i%0d_sat", k),   int'(st), m_sat[k]);
    check($sformatf("i%0d_rd_data", k), rd, m_rd[k]);
  endtask

  // One clock: model advances on the edge, outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge Clk_in);
    model_step();
    #1;
    cyc++;
    cmp_inst(0, rdy_d, bsy_d, dn_d, int'(tot_d), sat_d, int'(rd_d));
    cmp_inst(1, rdy_l, bsy_l, dn_l, int'(tot_l), sat_l, int'(rd_l));
    cmp_inst(2, rdy_s, bsy_s, dn_s, int'(tot_s), sat_s, int'(rd_s));
  endtask

  task automatic drive(input logic st, input logic v, input logic [3:0] d);
    start = st; data_valid = v; data_in = d;
    tick();
  endtask

  typedef struct {
    logic       start;
    logic       valid;
    logic [3:0] data;
    int         exp_total;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  vec_t vecs [7];
  int   exp_rd [16];

  initial begin
    // Basic run: 3,3,7,0 then terminator; Done one cycle after the terminator.
    vecs[0] = '{1'b1, 1'b0, 4'h0, 0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 4'h3, 1, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 4'h3, 2, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 4'h7, 3, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 4'h0, 4, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 4'hF, 4, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 4'h0, 4, 1'b0, 1'b1};
    for (int a = 0; a < 16; a++) exp_rd[a] = 0;
    exp_rd[0] = 1; exp_rd[3] = 2; exp_rd[7] = 1;

    // Reset overrides Start and data.
    nRst = 1'b0; start = 1'b1; data_valid = 1'b1; data_in = 4'h2; rd_addr = 4'h0;
    tick();
    tick();
    check("rst_busy", int'(bsy_d), 0);
    check("rst_done", int'(dn_d), 0);
    check("rst_ready", int'(rdy_d), 0);
    check("rst_total", int'(tot_d), 0);
    nRst = 1'b1;
    drive(1'b0, 1'b0, 4'h0);

    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].start, vecs[i].valid, vecs[i].data);
      check($sformatf("basic_total[%0d]", i), int'(tot_d), vecs[i].exp_total);
      check($sformatf("basic_busy[%0d]", i),  int'(bsy_d), int'(vecs[i].exp_busy));
      check($sformatf("basic_done[%0d]", i),  int'(dn_d),  int'(vecs[i].exp_done));
    end
    check("basic_sat", int'(sat_d), 0);

    // Readback sweep in DONE, one-cycle latency, out-of-range reads 0.
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      drive(1'b0, 1'b0, 4'h0);
      check($sformatf("sweep_rd[%0d]", a), int'(rd_d), exp_rd[a]);
    end

    // Length limit on MAX_LEN=8: ten 5s, Data_ready drops after the 8th.
    drive(1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 4'h5);
      if (i == 7) begin
        check("len_ready_after8", int'(rdy_l), 0);
        check("len_done_after8", int'(dn_l), 1);
      end
    end
    check("len_total", int'(tot_l), 8);
    drive(1'b0, 1'b1, 4'hF);
    rd_addr = 4'h5;
    drive(1'b0, 1'b0, 4'h0);
    check("len_count5", int'(rd_l), 8);
    check("len_def_count5", int'(rd_d), 10);

    // Saturation on CNT_W=3: nine 2s then terminator.
    drive(1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, 4'h2);
    drive(1'b0, 1'b1, 4'hF);
    rd_addr = 4'h2;
    drive(1'b0, 1'b0, 4'h0);
    check("sat_count2", int'(rd_s), 7);
    check("sat_total", int'(tot_s), 9);
    check("sat_flag", int'(sat_s), 1);
    check("sat_def_flag", int'(sat_d), 0);

    // Randomised traffic with gaps and stray Start pulses.
    drive(1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 150; i++) begin
      rd_addr = 4'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)));
    end
    drive(1'b0, 1'b1, 4'hC);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      drive(1'b0, 1'b0, 4'h0);
    end

    // Reset mid-run discards the partial run; a new run then works.
    drive(1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 4'h6);
    rd_addr = 4'h6;
    nRst = 1'b0;
    drive(1'b0, 1'b1, 4'h6);
    nRst = 1'b1;
    check("mid_rst_busy", int'(bsy_d), 0);
    check("mid_rst_done", int'(dn_d), 0);
    check("mid_rst_total", int'(tot_d), 0);
    check("mid_rst_rd", int'(rd_d), 0);
    drive(1'b0, 1'b0, 4'h0);
    check("mid_rst_count6", int'(rd_d), 0);
    check("mid_rst_no_done", int'(dn_d), 0);
    drive(1'b1, 1'b0, 4'h0);
    drive(1'b0, 1'b1, 4'h1);
    drive(1'b0, 1'b1, 4'h1);
    drive(1'b0, 1'b1, 4'hA);
    check("rerun_done", int'(dn_d), 1);
    check("rerun_total", int'(tot_d), 2);
    rd_addr = 4'h1;
    drive(1'b0, 1'b0, 4'h0);
    check("rerun_count1", int'(rd_d), 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
